// File: rtl/sb_cfg_pkg.sv
// Shared constants and state encoding for the
// switch-box serial configuration loader.
`timescale 1ns/1ps
package sb_cfg_pkg;

  localparam int SB_CFG_NBITS = 60;
  localparam int SB_SYNC_W = 8;
  localparam logic [7:0] SB_SYNC_WORD = 8'hA5;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  typedef enum logic [1:0] {
    HUNT   = ST_HUNT,
    LOAD   = ST_LOAD,
    PARITY = ST_PARITY,
    COMMIT = ST_COMMIT
  } cfg_state_e;

endpackage

// File: rtl/sb_sync_detect.sv
// Sync-word hunter: shift register with clear,
// hit flag looks at the value about to be stored.
`timescale 1ns/1ps
module sb_sync_detect
  import sb_cfg_pkg::*;
#(
  parameter int SYNC_W = SB_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SB_SYNC_WORD
) (
  input  logic clk,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic hit
);

  logic [SYNC_W-1:0] sr;
  logic [SYNC_W-1:0] sr_nxt;

  assign sr_nxt = {sr[SYNC_W-2:0], din};
  assign hit = en && (sr_nxt == SYNC_WORD);

  // shift accepted bits in; clear wins over shift
  always_ff @(posedge clk) begin
    if (clr) begin
      sr <= '0;
    end else if (en) begin
      sr <= sr_nxt;
    end
  end

endmodule

// File: rtl/sb_config_loader.sv
// Framed serial loader: hunts sync, shadows the payload,
// checks parity and commits roofconn in one cycle.
`timescale 1ns/1ps
module sb_config_loader
  import sb_cfg_pkg::*;
#(
  parameter int NBITS = SB_CFG_NBITS,
  parameter int SYNC_W = SB_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SB_SYNC_WORD
) (
  input  logic clk,
  input  logic reset,
  input  logic cfg_valid,
  input  logic cfg_data,
  output logic cfg_ready,
  input  logic abort,
  output logic [NBITS-1:0] roofconn,
  output logic cfg_busy,
  output logic cfg_done,
  output logic cfg_err,
  output logic [$clog2(NBITS+1)-1:0] cfg_count
);

  localparam int CW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  cfg_state_e state;
  cfg_state_e state_d;

  logic [NBITS-1:0] shadow;
  logic par;
  logic accept;
  logic hit;
  logic sync_en;
  logic sync_clr;
  logic load_bit;
  logic par_bad;
  logic do_commit;

  assign accept = cfg_valid && cfg_ready;
  assign sync_clr = !reset || abort || hit;

  sb_sync_detect #(
    .SYNC_W(SYNC_W),
    .SYNC_WORD(SYNC_WORD)
  ) u_sync (
    .clk(clk),
    .en(sync_en),
    .clr(sync_clr),
    .din(cfg_data),
    .hit(hit)
  );

  // next state and per-cycle actions; abort overrides
  always_comb begin
    state_d = state;
    sync_en = 1'b0;
    load_bit = 1'b0;
    par_bad = 1'b0;
    do_commit = 1'b0;
    if (abort) begin
      state_d = HUNT;
    end else begin
      unique case (state)
        HUNT: begin
          sync_en = accept;
          if (hit) state_d = LOAD;
        end
        LOAD: begin
          if (accept) begin
            load_bit = 1'b1;
            if (cfg_count == LAST) state_d = PARITY;
          end
        end
        PARITY: begin
          if (accept) begin
            if (par ^ cfg_data) begin
              par_bad = 1'b1;
              state_d = HUNT;
            end else begin
              state_d = COMMIT;
            end
          end
        end
        COMMIT: begin
          do_commit = 1'b1;
          state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= HUNT;
    end else begin
      state <= state_d;
    end
  end

  // registered flags, shadow, parity and commit
  always_ff @(posedge clk) begin
    if (!reset) begin
      roofconn <= '0;
      shadow <= '0;
      par <= 1'b0;
      cfg_count <= '0;
      cfg_ready <= 1'b0;
      cfg_busy <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_ready <= (state_d != COMMIT);
      cfg_busy <= (state_d != HUNT);
      cfg_done <= do_commit;
      cfg_err <= par_bad;
      if (abort || hit) begin
        shadow <= '0;
        par <= 1'b0;
        cfg_count <= '0;
      end else if (load_bit) begin
        shadow[cfg_count] <= cfg_data;
        par <= par ^ cfg_data;
        cfg_count <= cfg_count + 1'b1;
      end else if (par_bad) begin
        cfg_count <= '0;
      end else if (do_commit) begin
        roofconn <= shadow;
        cfg_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sb_config_loader.sv
// Directed plus randomized frames against a
// frame-level model of the configuration loader.
`timescale 1ns/1ps
module tb_sb_config_loader;

  logic clk = 1'b0;
  logic reset;
  logic cfg_valid;
  logic cfg_data;
  logic cfg_ready;
  logic abort;
  logic [59:0] roofconn;
  logic cfg_busy;
  logic cfg_done;
  logic cfg_err;
  logic [5:0] cfg_count;

  int checks = 0;
  int failures = 0;
  logic [59:0] exp_roof = '0;

  sb_config_loader dut (
    .clk(clk),
    .reset(reset),
    .cfg_valid(cfg_valid),
    .cfg_data(cfg_data),
    .cfg_ready(cfg_ready),
    .abort(abort),
    .roofconn(roofconn),
    .cfg_busy(cfg_busy),
    .cfg_done(cfg_done),
    .cfg_err(cfg_err),
    .cfg_count(cfg_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) chk("done_err_excl", cfg_done && cfg_err, 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int n;
    n = 0;
    cfg_valid = 1'b1;
    cfg_data = b;
    while (!cfg_ready && n < 20) begin
      step();
      n++;
    end
    if (!cfg_ready) chk("ready_timeout", 0, 1);
    step();
  endtask

  task automatic gap();
    int k;
    k = $urandom_range(0, 2);
    if (k != 0) begin
      cfg_valid = 1'b0;
      cfg_data = 1'($urandom);
      repeat (k) step();
    end
  endtask

  task automatic send_frame(input logic [59:0] pl, input bit good,
                            input bit gaps, input int stop_at);
    logic [7:0] sw;
    sw = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      if (gaps) gap();
      send_bit(sw[i]);
    end
    chk("sync_busy", cfg_busy, 1);
    chk("sync_count", cfg_count, 0);
    for (int i = 0; i < stop_at; i++) begin
      if (gaps) gap();
      send_bit(pl[i]);
      chk("load_count", cfg_count, i + 1);
    end
    if (stop_at < 60) begin
      cfg_valid = 1'b0;
      return;
    end
    if (gaps) gap();
    send_bit(^pl ^ !good);
    cfg_valid = 1'b0;
    if (good) begin
      chk("commit_ready", cfg_ready, 0);
      chk("commit_busy", cfg_busy, 1);
      chk("commit_count", cfg_count, 60);
      chk("commit_nodone", cfg_done, 0);
      chk("commit_roof_old", roofconn, exp_roof);
      step();
      exp_roof = pl;
      chk("done_roof", roofconn, exp_roof);
      chk("done_pulse", cfg_done, 1);
      chk("done_noerr", cfg_err, 0);
      chk("done_ready", cfg_ready, 1);
      chk("done_count", cfg_count, 0);
      chk("done_busy", cfg_busy, 0);
      step();
      chk("done_clear", cfg_done, 0);
    end else begin
      chk("err_pulse", cfg_err, 1);
      chk("err_ready", cfg_ready, 1);
      chk("err_busy", cfg_busy, 0);
      chk("err_roof", roofconn, exp_roof);
      step();
      chk("err_clear", cfg_err, 0);
      chk("err_nodone", cfg_done, 0);
    end
  endtask

  function automatic bit junk_ok(input logic [7:0] j, input int n);
    logic [15:0] s;
    s = {j, 8'hA5};
    for (int st = 0; st < n; st++) begin
      if (s[8 + n - 1 - st -: 8] == 8'hA5) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic send_junk(input logic [7:0] j, input int n);
    for (int k = n - 1; k >= 0; k--) send_bit(j[k]);
    chk("junk_busy", cfg_busy, 0);
    chk("junk_count", cfg_count, 0);
  endtask

  initial begin
    logic [59:0] pl;
    logic [63:0] r64;
    logic [7:0] sw;
    logic [7:0] jk;
    int jn;
    bit good;

    reset = 1'b0;
    cfg_valid = 1'b0;
    cfg_data = 1'b0;
    abort = 1'b0;
    step();
    step();
    chk("rst_roof", roofconn, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_count", cfg_count, 0);
    reset = 1'b1;
    step();
    chk("rel_ready", cfg_ready, 1);

    send_frame(60'h15, 1'b1, 1'b0, 60);
    send_frame(60'h15, 1'b0, 1'b0, 60);

    send_junk(8'b101, 3);
    send_frame({60{1'b1}}, 1'b1, 1'b0, 60);
    chk("ones_roof", roofconn, 60'hFFF_FFFF_FFFF_FFFF);

    send_frame(60'h15, 1'b1, 1'b0, 60);
    send_frame(60'h3, 1'b1, 1'b0, 30);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_roof", roofconn, 60'h15);
    chk("abort_count", cfg_count, 0);
    chk("abort_err", cfg_err, 0);
    chk("abort_busy", cfg_busy, 0);
    chk("abort_ready", cfg_ready, 1);

    r64 = {$urandom(), $urandom()};
    pl = r64[59:0];
    sw = 8'hA5;
    for (int k = 0; k < 8; k++) pl[8 + k] = sw[7 - k];
    send_frame(pl, 1'b1, 1'b1, 60);

    for (int f = 0; f < 12; f++) begin
      r64 = {$urandom(), $urandom()};
      pl = r64[59:0];
      good = ($urandom_range(0, 3) != 0);
      jn = $urandom_range(0, 5);
      jk = 8'($urandom);
      for (int t = 0; t < 10 && !junk_ok(jk, jn); t++) jk = 8'($urandom);
      if (!junk_ok(jk, jn)) jn = 0;
      if (jn != 0) send_junk(jk, jn);
      send_frame(pl, good, 1'b1, 60);
    end

    send_frame(60'hABC_DEF0_1234_5678, 1'b1, 1'b0, 60);
    send_frame(60'h1, 1'b1, 1'b0, 40);
    reset = 1'b0;
    step();
    exp_roof = '0;
    chk("mid_rst_roof", roofconn, exp_roof);
    chk("mid_rst_ready", cfg_ready, 0);
    chk("mid_rst_busy", cfg_busy, 0);
    chk("mid_rst_done", cfg_done, 0);
    chk("mid_rst_err", cfg_err, 0);
    chk("mid_rst_count", cfg_count, 0);
    reset = 1'b1;
    chk("mid_rst_hold", cfg_ready, 0);
    step();
    chk("mid_rst_rel", cfg_ready, 1);
    send_frame(60'h15, 1'b1, 1'b1, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
